// File: rtl/jane_pkg.sv
// Shared constants and FSM state type for the digit min/max block.
package jane_pkg;

  localparam int MAX_DIGITS = 10;
  localparam int VAL_W      = 34;
  localparam int DIGIT_W    = 4;
  localparam int NUM_BINS   = 10;

  typedef enum logic [1:0] {
    IDLE,
    SPLIT,
    BUILD,
    DONE
  } stateT;

endpackage

// File: rtl/digit_min_max_if.sv
// Operand/result handshake bundle for digit_min_max.
// Carries diffVal only when DIGIT_MM_KAPREKAR_DIFF_EN is defined.
interface digit_min_max_if #(
  parameter int VAL_W = jane_pkg::VAL_W
);

  logic             inValid;
  logic             inReady;
  logic [31:0]      in;
  logic             outValid;
  logic             outReady;
  logic [VAL_W-1:0] minVal;
  logic [VAL_W-1:0] maxVal;
  logic [3:0]       len;
`ifdef DIGIT_MM_KAPREKAR_DIFF_EN
  logic [VAL_W-1:0] diffVal;

  modport master (
    output inValid, in, outReady,
    input  inReady, outValid, minVal, maxVal, len, diffVal
  );

  modport slave (
    input  inValid, in, outReady,
    output inReady, outValid, minVal, maxVal, len, diffVal
  );
`else
  modport master (
    output inValid, in, outReady,
    input  inReady, outValid, minVal, maxVal, len
  );

  modport slave (
    input  inValid, in, outReady,
    output inReady, outValid, minVal, maxVal, len
  );
`endif

endinterface

// File: rtl/digit_min_max_div_mod10.sv
// Combinational divide-by-ten: quotient and decimal remainder digit.
module div_mod10 (
  input  logic [31:0] dividend,
  output logic [31:0] quotient,
  output logic [3:0]  remainder
);

  assign quotient  = dividend / 32'd10;
  assign remainder = 4'(dividend - quotient * 32'd10);

endmodule

// File: rtl/digit_min_max.sv
// Decomposes an operand into decimal digits and rebuilds them sorted ascending/descending.
// Optional diffVal output (maxVal - minVal) when DIGIT_MM_KAPREKAR_DIFF_EN is defined.
module digit_min_max
  import jane_pkg::*;
#(
  parameter int MAX_DIGITS = jane_pkg::MAX_DIGITS,
  parameter int VAL_W      = jane_pkg::VAL_W
) (
  input  logic           clk,
  input  logic           rst_n,
  digit_min_max_if.slave bus
);

  stateT              state;
  logic [31:0]        rem;
  logic [31:0]        quot;
  logic [DIGIT_W-1:0] remDigit;
  logic [DIGIT_W-1:0] histMin [NUM_BINS];
  logic [DIGIT_W-1:0] histMax [NUM_BINS];
  logic [DIGIT_W-1:0] lenCnt;
  logic [DIGIT_W-1:0] buildCnt;
  logic [DIGIT_W-1:0] minPtr;
  logic [DIGIT_W-1:0] maxPtr;
  logic [DIGIT_W-1:0] minDigit;
  logic [DIGIT_W-1:0] maxDigit;
  logic               minFound;
  logic               maxFound;
  logic [VAL_W-1:0]   accMin;
  logic [VAL_W-1:0]   accMax;

  div_mod10 uDiv (
    .dividend  (rem),
    .quotient  (quot),
    .remainder (remDigit)
  );

  // Empty bins are skipped in the same cycle: first non-empty bin at or past each pointer.
  always_comb begin
    minDigit = '0;
    minFound = 1'b0;
    for (int unsigned i = 0; i < NUM_BINS; i++) begin
      if (!minFound && DIGIT_W'(i) >= minPtr && histMin[DIGIT_W'(i)] != '0) begin
        minDigit = DIGIT_W'(i);
        minFound = 1'b1;
      end
    end
    maxDigit = '0;
    maxFound = 1'b0;
    for (int unsigned i = 0; i < NUM_BINS; i++) begin
      if (!maxFound && DIGIT_W'(NUM_BINS - 1 - i) <= maxPtr &&
          histMax[DIGIT_W'(NUM_BINS - 1 - i)] != '0) begin
        maxDigit = DIGIT_W'(NUM_BINS - 1 - i);
        maxFound = 1'b1;
      end
    end
  end

  // Results are latched into the output registers on the first DONE cycle,
  // with outValid rising alongside them one edge after the final BUILD step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rem          <= '0;
      histMin      <= '{default: '0};
      histMax      <= '{default: '0};
      lenCnt       <= '0;
      buildCnt     <= '0;
      minPtr       <= '0;
      maxPtr       <= DIGIT_W'(NUM_BINS - 1);
      accMin       <= '0;
      accMax       <= '0;
      bus.inReady  <= 1'b1;
      bus.outValid <= 1'b0;
      bus.minVal   <= '0;
      bus.maxVal   <= '0;
      bus.len      <= '0;
`ifdef DIGIT_MM_KAPREKAR_DIFF_EN
      bus.diffVal  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.inValid) begin
            rem         <= bus.in;
            histMin     <= '{default: '0};
            histMax     <= '{default: '0};
            lenCnt      <= '0;
            buildCnt    <= '0;
            minPtr      <= '0;
            maxPtr      <= DIGIT_W'(NUM_BINS - 1);
            accMin      <= '0;
            accMax      <= '0;
            bus.inReady <= 1'b0;
            state       <= SPLIT;
          end
        end

        SPLIT: begin
          histMin[remDigit] <= histMin[remDigit] + 1'b1;
          histMax[remDigit] <= histMax[remDigit] + 1'b1;
          lenCnt            <= lenCnt + 1'b1;
          rem               <= quot;
          if (quot == '0 || lenCnt == DIGIT_W'(MAX_DIGITS - 1)) begin
            state <= BUILD;
          end
        end

        BUILD: begin
          histMin[minDigit] <= histMin[minDigit] - 1'b1;
          histMax[maxDigit] <= histMax[maxDigit] - 1'b1;
          minPtr            <= minDigit;
          maxPtr            <= maxDigit;
          accMin            <= accMin * VAL_W'(10) + VAL_W'(minDigit);
          accMax            <= accMax * VAL_W'(10) + VAL_W'(maxDigit);
          buildCnt          <= buildCnt + 1'b1;
          if (buildCnt == lenCnt - 1'b1) begin
            state <= DONE;
          end
        end

        DONE: begin
          if (!bus.outValid) begin
            bus.minVal   <= accMin;
            bus.maxVal   <= accMax;
            bus.len      <= lenCnt;
`ifdef DIGIT_MM_KAPREKAR_DIFF_EN
            bus.diffVal  <= accMax - accMin;
`endif
            bus.outValid <= 1'b1;
          end else if (bus.outReady) begin
            bus.outValid <= 1'b0;
            bus.inReady  <= 1'b1;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_min_max.sv
// Self-checking bench for digit_min_max: fixed vectors, random operands vs a counting-sort model,
// DONE back-pressure and mid-operation reset sequences.
module tb_digit_min_max;

  localparam int VW = 34;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  digit_min_max_if #(.VAL_W(VW)) bus ();

  digit_min_max #(
    .MAX_DIGITS (10),
    .VAL_W      (VW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nVec  = 0;
  int nFail = 0;

  typedef struct {
    logic [31:0]     v;
    int unsigned     len;
    longint unsigned mn;
    longint unsigned mx;
  } vecT;

  vecT tbl [9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Digit histogram, then emit bins in order: independent of any FSM detail.
  function automatic void refModel(input logic [31:0] v, output int unsigned n,
                                   output longint unsigned mn, output longint unsigned mx);
    int unsigned     cnt [10];
    longint unsigned x;
    for (int d = 0; d < 10; d++) cnt[d] = 0;
    x = longint'(v);
    n = 0;
    do begin
      cnt[int'(x % 10)]++;
      x = x / 10;
      n++;
    end while (x != 0);
    mn = 0;
    mx = 0;
    for (int d = 0; d < 10; d++)
      for (int k = 0; k < int'(cnt[d]); k++) mn = mn * 10 + longint'(d);
    for (int d = 9; d >= 0; d--)
      for (int k = 0; k < int'(cnt[d]); k++) mx = mx * 10 + longint'(d);
  endfunction

  task automatic doOp(input logic [31:0] v, input bit ack, input int unsigned expLen,
                      input longint unsigned expMin, input longint unsigned expMax,
                      input string tag);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!bus.inReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, " inReady timeout"}, 64'(bus.inReady), 64'd1);
    bus.in      = v;
    bus.inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inValid = 1'b0;
    lat = 0;
    while (!bus.outValid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(2 * expLen + 1));
    check({tag, " len"}, 64'(bus.len), 64'(expLen));
    check({tag, " minVal"}, 64'(bus.minVal), expMin);
    check({tag, " maxVal"}, 64'(bus.maxVal), expMax);
`ifdef DIGIT_MM_KAPREKAR_DIFF_EN
    check({tag, " diffVal"}, 64'(bus.diffVal), expMax - expMin);
`endif
    if (ack) begin
      bus.outReady = 1'b1;
      @(negedge clk);
      bus.outReady = 1'b0;
      check({tag, " idle inReady"}, 64'(bus.inReady), 64'd1);
      check({tag, " idle outValid"}, 64'(bus.outValid), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned     rl;
    longint unsigned rmn;
    longint unsigned rmx;
    logic [31:0]     rv;
    int              quiet;

    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    bus.in       = '0;

    tbl[0] = '{32'd100,        3,  64'd1,          64'd100};
    tbl[1] = '{32'd4321,       4,  64'd1234,       64'd4321};
    tbl[2] = '{32'd1234,       4,  64'd1234,       64'd4321};
    tbl[3] = '{32'd0,          1,  64'd0,          64'd0};
    tbl[4] = '{32'd4294967295, 10, 64'd2244567999, 64'd9997654422};
    tbl[5] = '{32'd7,          1,  64'd7,          64'd7};
    tbl[6] = '{32'd10,         2,  64'd1,          64'd10};
    tbl[7] = '{32'd1000000000, 10, 64'd1,          64'd1000000000};
    tbl[8] = '{32'd909,        3,  64'd99,         64'd990};

    #12;
    check("reset outValid", 64'(bus.outValid), 64'd0);
    check("reset minVal", 64'(bus.minVal), 64'd0);
    check("reset maxVal", 64'(bus.maxVal), 64'd0);
    check("reset len", 64'(bus.len), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset inReady", 64'(bus.inReady), 64'd1);

    for (int i = 0; i < 9; i++)
      doOp(tbl[i].v, 1'b1, tbl[i].len, tbl[i].mn, tbl[i].mx, $sformatf("tbl[%0d]", i));

    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0:       rv = $urandom;
        1:       rv = $urandom_range(0, 999);
        2:       rv = $urandom_range(0, 99999);
        default: rv = $urandom >> $urandom_range(0, 31);
      endcase
      refModel(rv, rl, rmn, rmx);
      doOp(rv, 1'b1, rl, rmn, rmx, $sformatf("rand[%0d]=%0d", i, rv));
    end

    // Back-pressure in DONE: results hold, new operand is not taken or queued.
    doOp(32'd5312, 1'b0, 4, 64'd1235, 64'd5321, "hold");
    for (int c = 0; c < 5; c++) begin
      bus.inValid = 1'b1;
      bus.in      = 32'd777;
      @(negedge clk);
      check($sformatf("hold[%0d] outValid", c), 64'(bus.outValid), 64'd1);
      check($sformatf("hold[%0d] inReady", c), 64'(bus.inReady), 64'd0);
      check($sformatf("hold[%0d] minVal", c), 64'(bus.minVal), 64'd1235);
      check($sformatf("hold[%0d] maxVal", c), 64'(bus.maxVal), 64'd5321);
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    @(negedge clk);
    bus.outReady = 1'b0;
    check("hold release inReady", 64'(bus.inReady), 64'd1);
    check("hold release outValid", 64'(bus.outValid), 64'd0);
    doOp(32'd21, 1'b1, 2, 64'd12, 64'd21, "after hold");

    // Reset in the middle of BUILD for a 10-digit operand.
    @(negedge clk);
    bus.in      = 32'd1234567890;
    bus.inValid = 1'b1;
    @(negedge clk);
    bus.inValid = 1'b0;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset outValid", 64'(bus.outValid), 64'd0);
    check("midreset minVal", 64'(bus.minVal), 64'd0);
    check("midreset maxVal", 64'(bus.maxVal), 64'd0);
    check("midreset len", 64'(bus.len), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset inReady", 64'(bus.inReady), 64'd1);
    quiet = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.outValid) quiet++;
    end
    check("midreset no partial result", 64'(quiet), 64'd0);
    doOp(32'd55, 1'b1, 2, 64'd55, 64'd55, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
